// File: rtl/multi_player_buzzer_if.sv
// Host/player/display bundle for the quiz buzzer: host and buttons drive the
// master side, the buzzer core sits on the slave side.
interface multi_player_buzzer_if #(
  parameter int N_PLAYERS = 4,
  parameter int IDX_W     = 2
) ();
  logic                 arm;
  logic                 clear;
  logic [N_PLAYERS-1:0] buzz;
  logic [N_PLAYERS-1:0] winner;
  logic [IDX_W-1:0]     winner_idx;
  logic                 win_valid;
  logic                 armed;
  logic                 timeout;
  logic [N_PLAYERS-1:0] penalty;

  modport master (
    output arm, clear, buzz,
    input  winner, winner_idx, win_valid, armed, timeout, penalty
  );

  modport slave (
    input  arm, clear, buzz,
    output winner, winner_idx, win_valid, armed, timeout, penalty
  );
endinterface

// File: rtl/multi_player_buzzer.sv
// N-player quiz buzzer: first rising press wins (lowest index on ties), 1-cycle press-to-winner latency, no backpressure.
// Define BUZZER_SYNC_EN to add a 2-flop synchroniser on buzz (+2 cycles latency).
module multi_player_buzzer #(
  parameter int N_PLAYERS      = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst,
  multi_player_buzzer_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [N_PLAYERS-1:0] buzz_e;
  logic [N_PLAYERS-1:0] buzz_d;
  logic [N_PLAYERS-1:0] rise;
  logic [N_PLAYERS-1:0] press;
  logic [N_PLAYERS-1:0] first_oh;
  logic [IDX_W-1:0]     first_idx;

  logic [N_PLAYERS-1:0] winner;
  logic [IDX_W-1:0]     winner_idx;
  logic                 win_valid;
  logic                 armed;
  logic                 timeout;
  logic [N_PLAYERS-1:0] penalty;

`ifdef BUZZER_SYNC_EN
  logic [N_PLAYERS-1:0] sync_q1;
  logic [N_PLAYERS-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.buzz;
      sync_q2 <= sync_q1;
    end
  end

  assign buzz_e = sync_q2;
`else
  assign buzz_e = bus.buzz;
`endif

  assign rise  = buzz_e & ~buzz_d;
  assign press = rise & ~penalty;

  // Two's-complement trick isolates the lowest set bit for the tie-break.
  assign first_oh = press & (~press + 1'b1);

  always_comb begin
    first_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (press[i]) first_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      buzz_d     <= '0;
      winner     <= '0;
      winner_idx <= '0;
      win_valid  <= 1'b0;
      armed      <= 1'b0;
      timeout    <= 1'b0;
      penalty    <= '0;
    end else begin
      buzz_d <= buzz_e;
      // clear outranks arm, press and timeout in every state.
      if (bus.clear) begin
        state      <= IDLE;
        winner     <= '0;
        winner_idx <= '0;
        win_valid  <= 1'b0;
        armed      <= 1'b0;
        timeout    <= 1'b0;
        penalty    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            penalty <= penalty | rise;
            if (bus.arm) begin
              state <= ARMED;
              armed <= 1'b1;
              cnt   <= '0;
            end
          end
          ARMED: begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (|press) begin
              state      <= LOCKED;
              winner     <= first_oh;
              winner_idx <= first_idx;
              win_valid  <= 1'b1;
              armed      <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state   <= TIMEOUT;
              armed   <= 1'b0;
              timeout <= 1'b1;
            end
          end
          LOCKED:  state <= LOCKED;
          TIMEOUT: state <= TIMEOUT;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.winner     = winner;
  assign bus.winner_idx = winner_idx;
  assign bus.win_valid  = win_valid;
  assign bus.armed      = armed;
  assign bus.timeout    = timeout;
  assign bus.penalty    = penalty;
endmodule

// File: tb/tb_multi_player_buzzer.sv
// Directed bench for multi_player_buzzer with N_PLAYERS=4, TIMEOUT_CYCLES=8.
module tb_multi_player_buzzer;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  multi_player_buzzer_if #(.N_PLAYERS(4), .IDX_W(2)) bus ();

  multi_player_buzzer #(
    .N_PLAYERS     (4),
    .IDX_W         (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [3:0] pen);
    check({tag, "_winner"}, 32'(bus.winner), 32'h0);
    check({tag, "_idx"}, 32'(bus.winner_idx), 32'h0);
    check({tag, "_valid"}, 32'(bus.win_valid), 32'h0);
    check({tag, "_armed"}, 32'(bus.armed), 32'h0);
    check({tag, "_timeout"}, 32'(bus.timeout), 32'h0);
    check({tag, "_penalty"}, 32'(bus.penalty), 32'(pen));
  endtask

  initial begin
    // 1: reset with all buttons held
    rst       = 1'b1;
    bus.arm   = 1'b0;
    bus.clear = 1'b0;
    bus.buzz  = 4'b1111;
    tick();
    tick();
    check_idle("reset", 4'b0000);
    rst      = 1'b0;
    bus.buzz = 4'b0000;
    tick();
    check_idle("post_reset", 4'b0000);

    // 2: single winner, later presses ignored, clear
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check("t2_armed", 32'(bus.armed), 32'h1);
    tick();
    tick();
    bus.buzz = 4'b0100;
    tick();
    check("t2_winner", 32'(bus.winner), 32'h4);
    check("t2_idx", 32'(bus.winner_idx), 32'h2);
    check("t2_valid", 32'(bus.win_valid), 32'h1);
    check("t2_armed_off", 32'(bus.armed), 32'h0);
    bus.buzz = 4'b0101;
    tick();
    check("t2_hold_winner", 32'(bus.winner), 32'h4);
    check("t2_hold_idx", 32'(bus.winner_idx), 32'h2);
    bus.buzz  = 4'b0000;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check_idle("t2_clear", 4'b0000);

    // 3: simultaneous presses, lowest index wins
    bus.arm = 1'b1;
    tick();
    bus.arm  = 1'b0;
    bus.buzz = 4'b1010;
    tick();
    check("t3_winner", 32'(bus.winner), 32'h2);
    check("t3_idx", 32'(bus.winner_idx), 32'h1);
    bus.buzz  = 4'b0000;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;

    // 4: false start locks player 3 out, round times out
    bus.buzz = 4'b1000;
    tick();
    bus.buzz = 4'b0000;
    check("t4_penalty", 32'(bus.penalty), 32'h8);
    tick();
    bus.arm = 1'b1;
    tick();
    bus.arm  = 1'b0;
    bus.buzz = 4'b1000;
    tick();
    check("t4_no_win", 32'(bus.win_valid), 32'h0);
    repeat (6) tick();
    check("t4_armed_cnt7", 32'(bus.armed), 32'h1);
    check("t4_not_yet_timeout", 32'(bus.timeout), 32'h0);
    tick();
    check("t4_timeout", 32'(bus.timeout), 32'h1);
    check("t4_armed_off", 32'(bus.armed), 32'h0);
    check("t4_penalty_kept", 32'(bus.penalty), 32'h8);
    bus.buzz  = 4'b0000;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check_idle("t4_clear", 4'b0000);

    // 5: held button before arm gives no rising edge inside the round
    bus.buzz = 4'b0001;
    tick();
    check("t5_penalty", 32'(bus.penalty), 32'h1);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    tick();
    check("t5_no_win", 32'(bus.win_valid), 32'h0);
    bus.buzz = 4'b0011;
    tick();
    check("t5_winner", 32'(bus.winner), 32'h2);
    check("t5_idx", 32'(bus.winner_idx), 32'h1);
    bus.buzz  = 4'b0000;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;

    // 6a: press on the final count beats timeout
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (7) tick();
    bus.buzz = 4'b0100;
    tick();
    check("t6_last_idx", 32'(bus.winner_idx), 32'h2);
    check("t6_last_valid", 32'(bus.win_valid), 32'h1);
    check("t6_last_timeout", 32'(bus.timeout), 32'h0);
    bus.buzz  = 4'b0000;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;

    // 6b: clear beats a press on the same edge
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (7) tick();
    bus.clear = 1'b1;
    bus.buzz  = 4'b0100;
    tick();
    bus.clear = 1'b0;
    bus.buzz  = 4'b0000;
    check_idle("t6_clear_press", 4'b0000);

    // clear beats arm when both are high
    bus.arm   = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.arm   = 1'b0;
    bus.clear = 1'b0;
    check("t6_clear_over_arm", 32'(bus.armed), 32'h0);

    // 6c: reset while LOCKED
    bus.arm = 1'b1;
    tick();
    bus.arm  = 1'b0;
    bus.buzz = 4'b0001;
    tick();
    check("t6_locked", 32'(bus.win_valid), 32'h1);
    check("t6_locked_idx", 32'(bus.winner_idx), 32'h0);
    check("t6_locked_oh", 32'(bus.winner), 32'h1);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    bus.buzz = 4'b0000;
    check_idle("t6_rst_locked", 4'b0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
